// File: rtl/spi_rx_packer_if.sv
// Stream bundle between spi_core rx, the packer and the rx FIFO.
// slave = packer side, master = producer/consumer side.
interface spi_rx_packer_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic [1:0]  rdtb_i;
  logic        lsb_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [2:0]  out_bytes_o;

  modport slave (
    input  in_valid_i, in_data_i, rdtb_i, lsb_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_bytes_o
  );

  modport master (
    output in_valid_i, in_data_i, rdtb_i, lsb_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_bytes_o
  );
endinterface

// File: rtl/spi_rx_packer.sv
// Repacks 8/16/24/32-bit rx units into dense little-endian 32-bit words,
// with flush/idle-timeout partial words and a one-unit-per-word bypass.
module spi_rx_packer #(
  parameter int TMO_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 pack_en_i,
  input  logic                 flush_i,
  input  logic [TMO_WIDTH-1:0] timeout_i,
  output logic                 busy_o,
  spi_rx_packer_if.slave       bus
);

  // Handshake: both streams transfer on a rising clk_i edge where valid and
  // ready are both high; valid never waits on ready, and a raised
  // out_valid_o holds its data and byte count until it is taken.

  logic [63:0]          acc_q, acc_d;
  logic [3:0]           acc_cnt_q, acc_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_data_q, out_data_d;
  logic [2:0]           out_bytes_q, out_bytes_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [TMO_WIDTH-1:0] idle_q, idle_d;

  logic [3:0]           n_bytes;
  logic [31:0]          unit_pk, unit_bp;
  logic                 out_free, in_ready, accept, tmo_hit;
  logic [TMO_WIDTH:0]   idle_inc;

  assign n_bytes  = {2'b00, bus.rdtb_i} + 4'd1;
  assign out_free = ~out_valid_q | bus.out_ready_i;
  assign idle_inc = {1'b0, idle_q} + {{TMO_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    if (pack_en_i)
      in_ready = en_i & ~flush_pend_q & ((acc_cnt_q + n_bytes) <= 4'd8);
    else
      in_ready = en_i & ~flush_pend_q & (acc_cnt_q == 4'd0) & out_free;
  end

  assign accept = bus.in_valid_i & in_ready;

  // unit_pk places the first stream byte in [7:0]; unit_bp is right-aligned.
  always_comb begin
    unit_bp = '0;
    unit_pk = '0;
    case (bus.rdtb_i)
      2'd0: begin
        unit_bp = {24'd0, bus.in_data_i[7:0]};
        unit_pk = unit_bp;
      end
      2'd1: begin
        unit_bp = {16'd0, bus.in_data_i[15:0]};
        unit_pk = bus.lsb_i ? unit_bp
                            : {16'd0, bus.in_data_i[7:0], bus.in_data_i[15:8]};
      end
      2'd2: begin
        unit_bp = {8'd0, bus.in_data_i[23:0]};
        unit_pk = bus.lsb_i ? unit_bp
                            : {8'd0, bus.in_data_i[7:0], bus.in_data_i[15:8],
                               bus.in_data_i[23:16]};
      end
      default: begin
        unit_bp = bus.in_data_i;
        unit_pk = bus.lsb_i ? unit_bp
                            : {bus.in_data_i[7:0], bus.in_data_i[15:8],
                               bus.in_data_i[23:16], bus.in_data_i[31:24]};
      end
    endcase
  end

  always_comb begin
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    out_valid_d  = out_valid_q & ~bus.out_ready_i;
    out_data_d   = out_data_q;
    out_bytes_d  = out_bytes_q;
    idle_d       = idle_q;
    tmo_hit      = 1'b0;
    flush_pend_d = flush_pend_q;

    // Drain happens before append so a new unit lands after the leftover bytes.
    if (out_free && (acc_cnt_q >= 4'd4)) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q[31:0];
      out_bytes_d = 3'd4;
      acc_d       = {32'd0, acc_q[63:32]};
      acc_cnt_d   = acc_cnt_q - 4'd4;
    end else if (flush_pend_q && out_free && (acc_cnt_q != 4'd0)) begin
      // Bytes above acc_cnt are always zero, so the word is already padded.
      out_valid_d = 1'b1;
      out_data_d  = acc_q[31:0];
      out_bytes_d = acc_cnt_q[2:0];
      acc_d       = '0;
      acc_cnt_d   = 4'd0;
    end

    if (accept) begin
      if (pack_en_i) begin
        acc_d     = acc_d | ({32'd0, unit_pk} << {acc_cnt_d, 3'b000});
        acc_cnt_d = acc_cnt_d + n_bytes;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = unit_bp;
        out_bytes_d = n_bytes[2:0];
      end
    end

    if (accept || (acc_cnt_q == 4'd0)) begin
      idle_d = '0;
    end else if ((acc_cnt_q < 4'd4) && !flush_pend_q) begin
      idle_d  = idle_inc[TMO_WIDTH-1:0];
      tmo_hit = (timeout_i != '0) && (idle_inc >= {1'b0, timeout_i});
    end

    flush_pend_d = (flush_pend_q | flush_i | tmo_hit) & (acc_cnt_d != 4'd0);

    if (!en_i) begin
      acc_d        = '0;
      acc_cnt_d    = 4'd0;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      out_bytes_d  = 3'd0;
      idle_d       = '0;
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q        <= '0;
      acc_cnt_q    <= 4'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_bytes_q  <= 3'd0;
      idle_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_bytes_q  <= out_bytes_d;
      idle_q       <= idle_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q & en_i;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_bytes_o = out_bytes_q;
  assign busy_o          = (acc_cnt_q != 4'd0) | (out_valid_q & en_i) | flush_pend_q;

endmodule

// File: tb/tb_spi_rx_packer.sv
// Directed bench for spi_rx_packer: packing, flush, backpressure, timeout,
// bypass, sustained rate, enable clear and asynchronous reset.
module tb_spi_rx_packer;

  logic       clk = 1'b0;
  logic       rst, en, pack_en, flush;
  logic [7:0] timeout;
  logic       busy;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         start_cyc;
  logic [34:0] got_q[$];
  logic [34:0] exp_q[$];

  spi_rx_packer_if bus();

  spi_rx_packer #(.TMO_WIDTH(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .pack_en_i (pack_en),
    .flush_i   (flush),
    .timeout_i (timeout),
    .busy_o    (busy),
    .bus       (bus)
  );

  // clock / cycle counter / output monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always begin
    @(negedge clk);
    #2;
    if (bus.out_valid_o && bus.out_ready_i)
      got_q.push_back({bus.out_bytes_o, bus.out_data_o});
  end

  // Driver: present one unit at a negedge, return at the negedge after it is taken.
  task automatic drive_unit(input logic [1:0] sz, input logic l, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    bus.rdtb_i = sz; bus.lsb_i = l; bus.in_data_i = d; bus.in_valid_i = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (bus.in_ready_o) begin
        ok = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: unit %h in_ready_o=0 after 100 cycles, want accepted", d);
      bus.in_valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pack_en = 1'b1; flush = 1'b0; timeout = 8'd0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.rdtb_i = 2'd0; bus.lsb_i = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid_o); end
    total++; if (bus.out_data_o !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.out_data_o); end
    total++; if (bus.out_bytes_o !== 3'd0) begin bad++; $display("FAIL reset_bytes: got %0d want 0", bus.out_bytes_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pack_bytes();
    @(negedge clk);
    pack_en = 1'b1; bus.out_ready_i = 1'b0;
    drive_unit(2'd0, 1'b0, 32'h000000AA);
    drive_unit(2'd0, 1'b1, 32'h000000BB);
    drive_unit(2'd0, 1'b0, 32'h123456CC);
    drive_unit(2'd0, 1'b1, 32'h000000DD);
    bus.in_valid_i = 1'b0;
    #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL pack_early: out_valid got %b want 0", bus.out_valid_o); end
    @(negedge clk); #1;
    total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL pack_latency: out_valid got %b want 1", bus.out_valid_o); end
    total++; if (bus.out_data_o !== 32'hDDCCBBAA) begin bad++; $display("FAIL pack_data: got %h want DDCCBBAA", bus.out_data_o); end
    total++; if (bus.out_bytes_o !== 3'd4) begin bad++; $display("FAIL pack_bytes: got %0d want 4", bus.out_bytes_o); end
    got_q.delete();
    bus.out_ready_i = 1'b1;
    repeat (2) @(negedge clk); #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL pack_pop: out_valid got %b want 0", bus.out_valid_o); end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL pack_count: got %0d words want 1", got_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pack_busy: got %b want 0", busy); end
  endtask

  task automatic test_pack_flush();
    @(negedge clk);
    bus.out_ready_i = 1'b1; got_q.delete();
    exp_q = '{{3'd4, 32'h44332211}, {3'd2, 32'h00006655}};
    drive_unit(2'd2, 1'b0, 32'h00112233);
    drive_unit(2'd2, 1'b0, 32'h00445566);
    bus.in_valid_i = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (4) @(negedge clk); #1;
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL flush_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL flush_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 35'h0, exp_q[i]);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.out_ready_i = 1'b0; got_q.delete();
    exp_q = '{{3'd4, 32'h01020304}, {3'd4, 32'hA5A5F00F}, {3'd4, 32'hCAFEBABE}};
    drive_unit(2'd3, 1'b1, 32'h01020304);
    drive_unit(2'd3, 1'b1, 32'hA5A5F00F);
    drive_unit(2'd3, 1'b1, 32'hCAFEBABE);
    bus.in_data_i = 32'h99999999;
    #1;
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_full: in_ready got %b want 0", bus.in_ready_o); end
    repeat (3) @(negedge clk); #1;
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_hold: in_ready got %b want 0", bus.in_ready_o); end
    total++; if (bus.out_data_o !== 32'h01020304) begin bad++; $display("FAIL bp_stable: got %h want 01020304", bus.out_data_o); end
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    repeat (6) @(negedge clk); #1;
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 35'h0, exp_q[i]);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    bus.out_ready_i = 1'b1; timeout = 8'd5; got_q.delete();
    drive_unit(2'd0, 1'b1, 32'h0000005A);
    bus.in_valid_i = 1'b0;
    repeat (5) @(negedge clk); #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL tmo_early: out_valid got %b want 0", bus.out_valid_o); end
    @(negedge clk); #1;
    total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL tmo_fire: out_valid got %b want 1", bus.out_valid_o); end
    total++; if (bus.out_data_o !== 32'h0000005A) begin bad++; $display("FAIL tmo_data: got %h want 0000005A", bus.out_data_o); end
    total++; if (bus.out_bytes_o !== 3'd1) begin bad++; $display("FAIL tmo_bytes: got %0d want 1", bus.out_bytes_o); end
    repeat (2) @(negedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy: got %b want 0", busy); end
    timeout = 8'd0; got_q.delete();
    drive_unit(2'd0, 1'b1, 32'h00000077);
    bus.in_valid_i = 1'b0;
    repeat (20) @(negedge clk); #1;
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL tmo_off: got %0d words want 0", got_q.size()); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL tmo_off_busy: got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk); #1;
    total++;
    if (got_q.size() != 1 || got_q[0] !== {3'd1, 32'h00000077}) begin
      bad++; $display("FAIL tmo_off_flush: got %0d words first %h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 35'h0, {3'd1, 32'h00000077});
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    pack_en = 1'b0; bus.out_ready_i = 1'b1; got_q.delete();
    exp_q = '{{3'd2, 32'h0000BEEF}, {3'd1, 32'h00000078}, {3'd2, 32'h0000DEF0},
              {3'd3, 32'h001E2D3C}, {3'd4, 32'hDEADBEEF}};
    drive_unit(2'd1, 1'b0, 32'hFFFFBEEF);
    total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL byp_valid: got %b want 1", bus.out_valid_o); end
    total++; if (bus.out_data_o !== 32'h0000BEEF) begin bad++; $display("FAIL byp_data: got %h want 0000BEEF", bus.out_data_o); end
    total++; if (bus.out_bytes_o !== 3'd2) begin bad++; $display("FAIL byp_bytes: got %0d want 2", bus.out_bytes_o); end
    start_cyc = cyc;
    drive_unit(2'd0, 1'b1, 32'h12345678);
    drive_unit(2'd1, 1'b0, 32'h9ABCDEF0);
    drive_unit(2'd2, 1'b0, 32'h0F1E2D3C);
    drive_unit(2'd3, 1'b0, 32'hDEADBEEF);
    total++; if (cyc - start_cyc != 4) begin bad++; $display("FAIL byp_rate: got %0d cycles want 4", cyc - start_cyc); end
    bus.in_valid_i = 1'b0;
    repeat (3) @(negedge clk); #1;
    total++; if (got_q.size() != 5) begin bad++; $display("FAIL byp_count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL byp_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 35'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    pack_en = 1'b1; bus.out_ready_i = 1'b1; got_q.delete();
    exp_q = '{{3'd4, 32'h04030201}, {3'd4, 32'hA0B1C2D3}, {3'd4, 32'h44332211},
              {3'd4, 32'h55667788}, {3'd4, 32'hDDCCBBAA}, {3'd1, 32'h000000EE}};
    start_cyc = cyc;
    drive_unit(2'd3, 1'b0, 32'h01020304);
    drive_unit(2'd3, 1'b1, 32'hA0B1C2D3);
    drive_unit(2'd3, 1'b0, 32'h11223344);
    drive_unit(2'd3, 1'b1, 32'h55667788);
    total++; if (cyc - start_cyc != 4) begin bad++; $display("FAIL b2b_rate: got %0d cycles want 4", cyc - start_cyc); end
    drive_unit(2'd1, 1'b1, 32'h0000BBAA);
    drive_unit(2'd2, 1'b0, 32'h00CCDDEE);
    bus.in_valid_i = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (8) @(negedge clk); #1;
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 35'h0, exp_q[i]);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy: got %b want 0", busy); end
  endtask

  task automatic test_enable_clear();
    @(negedge clk);
    pack_en = 1'b1; bus.out_ready_i = 1'b1; got_q.delete();
    drive_unit(2'd2, 1'b1, 32'h00ABCDEF);
    bus.in_valid_i = 1'b0;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL en_busy_before: got %b want 1", busy); end
    en = 1'b0;
    #1;
    total++; if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL en_ready_low: got %b want 0", bus.in_ready_o); end
    @(negedge clk);
    en = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_cleared: busy got %b want 0", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL en_no_word: got %0d words want 0", got_q.size()); end
    drive_unit(2'd0, 1'b1, 32'h0000003C);
    bus.in_valid_i = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    bus.out_ready_i = 1'b0;
    drive_unit(2'd3, 1'b1, 32'h12345678);
    bus.in_valid_i = 1'b0;
    @(negedge clk); #1;
    total++; if (bus.out_valid_o !== 1'b1) begin bad++; $display("FAIL en_pending: out_valid got %b want 1", bus.out_valid_o); end
    en = 1'b0;
    #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL en_valid_gate: got %b want 0", bus.out_valid_o); end
    @(negedge clk);
    en = 1'b1;
    #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL en_valid_clear: got %b want 0", bus.out_valid_o); end
    bus.out_ready_i = 1'b1;
    repeat (3) @(negedge clk); #1;
    total++;
    if (got_q.size() != 1 || got_q[0] !== {3'd1, 32'h0000003C}) begin
      bad++; $display("FAIL en_words: got %0d words first %h want 1 word %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 35'h0, {3'd1, 32'h0000003C});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pack_en = 1'b1; bus.out_ready_i = 1'b0; got_q.delete();
    drive_unit(2'd3, 1'b1, 32'h11223344);
    drive_unit(2'd3, 1'b1, 32'h55667788);
    bus.in_valid_i = 1'b0;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy_before: got %b want 1", busy); end
    #1;
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.out_valid_o); end
    total++; if (bus.out_data_o !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.out_data_o); end
    total++; if (bus.out_bytes_o !== 3'd0) begin bad++; $display("FAIL rst_bytes: got %0d want 0", bus.out_bytes_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0; bus.out_ready_i = 1'b1;
    repeat (4) @(negedge clk); #1;
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rst_no_word: got %0d words want 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_pack_bytes();
    test_pack_flush();
    test_backpressure();
    test_timeout();
    test_bypass();
    test_back_to_back();
    test_enable_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
